ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arb_pkg.sv | 10 +
 rtl/rr_pick.sv | 14 +
 rtl/ram_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared widths, FSM state encoding and owner codes for the RAM arbiter.
// No ports; imported by rr_pick and ram_arbiter.
package ram_arb_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    localparam logic [1:0] OWN_IDLE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_HOST = 2'b10;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: two-way arbitration choice between cpu (index 0) and host (index 1).
// Ports: req[1:0] {host,cpu} requests, last = 1 when host won the previous grant,
//        fixed = 1 makes cpu win every tie, winner = 0 cpu / 1 host.
module rr_pick
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       fixed,
    output logic       winner
);
    // Host wins alone, or on a tie when round-robin says it is host's turn.
    assign winner = (req == 2'b10) || (req == 2'b11 && !fixed && !last);
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one 256x16 single-port synchronous RAM between a cpu and a host port.
// Ports: clock/reset (sync, active-high); per requester req/we/addr/wdata in,
//        gnt/rvalid pulses and held rdata out; ram_addr/ram_wdata/ram_wren/ram_q RAM bus;
//        owner = 00 idle, 01 cpu, 10 host.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              host_req,
    input  logic              cpu_we,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              cpu_gnt,
    output logic              host_gnt,
    output logic              cpu_rvalid,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic [1:0]        owner
);
    state_t state;
    logic   win;
    logic   last;
    logic   pick;

    rr_pick u_pick (
        .req    ({host_req, cpu_req}),
        .last   (last),
        .fixed  (FIXED_PRIO != 0),
        .winner (pick)
    );

    // ram_addr/ram_wdata double as the latched request: loaded on the grant
    // decision and left untouched until the next one, so they hold through RESP
    // and IDLE. ram_wren doubles as the latched we while in ACCESS.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            win         <= 1'b0;
            last        <= 1'b1;
            cpu_gnt     <= 1'b0;
            host_gnt    <= 1'b0;
            cpu_rvalid  <= 1'b0;
            host_rvalid <= 1'b0;
            cpu_rdata   <= '0;
            host_rdata  <= '0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            ram_wren    <= 1'b0;
            owner       <= OWN_IDLE;
        end else begin
            cpu_gnt     <= 1'b0;
            host_gnt    <= 1'b0;
            cpu_rvalid  <= 1'b0;
            host_rvalid <= 1'b0;
            ram_wren    <= 1'b0;
            case (state)
                IDLE: if (cpu_req || host_req) begin
                    state     <= ACCESS;
                    win       <= pick;
                    last      <= pick;
                    cpu_gnt   <= !pick;
                    host_gnt  <= pick;
                    owner     <= pick ? OWN_HOST : OWN_CPU;
                    ram_addr  <= pick ? host_addr : cpu_addr;
                    ram_wdata <= pick ? host_wdata : cpu_wdata;
                    ram_wren  <= pick ? host_we : cpu_we;
                end
                ACCESS: begin
                    state <= ram_wren ? IDLE : RESP;
                    if (ram_wren) owner <= OWN_IDLE;
                end
                RESP: begin
                    state <= IDLE;
                    owner <= OWN_IDLE;
                    if (win) begin
                        host_rvalid <= 1'b1;
                        host_rdata  <= ram_q;
                    end else begin
                        cpu_rvalid <= 1'b1;
                        cpu_rdata  <= ram_q;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
